// File: rtl/adc_readout_pkg.sv
// rtl/adc_readout_pkg.sv - shared constants and state encoding for ADC fill readout
package adc_readout_pkg;

    localparam int DW       = 128;
    localparam int BCNT_W   = 23;
    localparam int BCNT_LSB = 0;
    localparam int FCNT_W   = 24;

    localparam int HDR_BCNT_LSB = BCNT_LSB;
    localparam int HDR_BCNT_MSB = BCNT_LSB + BCNT_W - 1;

    localparam int ST_IDLE   = 0;
    localparam int ST_HDR    = 1;
    localparam int ST_DATA   = 2;
    localparam int ST_CHKSUM = 3;
    localparam int ST_DONE   = 4;
    localparam int ST_NUM    = 5;

    typedef enum logic [ST_NUM-1:0] {
        IDLE   = 5'b00001,
        HDR    = 5'b00010,
        DATA   = 5'b00100,
        CHKSUM = 5'b01000,
        DONE   = 5'b10000
    } state_e;

endpackage

// File: rtl/adc_readout_sm_sync2.sv
// rtl/adc_readout_sm_sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_readout_sm.sv
// rtl/adc_readout_sm.sv - pulls one stored fill from the DDR3 read FIFO and streams it out
module adc_readout_sm #(
    parameter int DW       = adc_readout_pkg::DW,
    parameter int BCNT_W   = adc_readout_pkg::BCNT_W,
    parameter int BCNT_LSB = adc_readout_pkg::BCNT_LSB,
    parameter int FCNT_W   = adc_readout_pkg::FCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              readout_req,
    input  logic              acq_enable0,
    input  logic              acq_enable1,
    input  logic [FCNT_W-1:0] fills_stored,
    input  logic [DW-1:0]     rd_fifo_data,
    input  logic              rd_fifo_empty,
    output logic              rd_fifo_rd_en,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              rd_addr_cntr_en,
    output logic              fill_cntr_dec,
    output logic              readout_busy,
    output logic              readout_done,
    output logic              no_data_err,
    output logic              chksum_err
);

    import adc_readout_pkg::*;

    logic              req_sync;
    logic              acq0_sync;
    logic              acq1_sync;
    logic              readout_mode;
    logic              active;
    logic              xfer;
    logic [BCNT_W-1:0] hdr_bcnt;
    logic [BCNT_W-1:0] remaining;
    logic [DW-1:0]     xor_acc;
    state_e            state;

    sync2 u_sync_req  (.clk(clk), .reset(reset), .d(readout_req), .q(req_sync));
    sync2 u_sync_acq0 (.clk(clk), .reset(reset), .d(acq_enable0), .q(acq0_sync));
    sync2 u_sync_acq1 (.clk(clk), .reset(reset), .d(acq_enable1), .q(acq1_sync));

    assign readout_mode    = ~acq0_sync & ~acq1_sync;
    assign active          = (state == HDR) | (state == DATA) | (state == CHKSUM);
    assign out_valid       = active & ~rd_fifo_empty;
    assign xfer            = out_valid & out_ready;
    assign rd_fifo_rd_en   = xfer;
    assign rd_addr_cntr_en = xfer;
    // Gated so the bus reads zero whenever nothing is being offered
    assign out_data        = out_valid ? rd_fifo_data : '0;
    assign out_last        = (state == CHKSUM) & out_valid;
    assign readout_busy    = (state != IDLE);
    assign readout_done    = (state == DONE);
    assign hdr_bcnt        = rd_fifo_data[BCNT_LSB +: BCNT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remaining     <= '0;
            xor_acc       <= '0;
            fill_cntr_dec <= 1'b0;
            no_data_err   <= 1'b0;
            chksum_err    <= 1'b0;
        end else begin
            fill_cntr_dec <= 1'b0;
            no_data_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_sync && readout_mode) begin
                        if (fills_stored == '0) begin
                            no_data_err <= 1'b1;
                            state       <= DONE;
                        end else begin
                            chksum_err <= 1'b0;
                            xor_acc    <= '0;
                            state      <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (xfer) begin
                        remaining <= hdr_bcnt;
                        xor_acc   <= rd_fifo_data;
                        state     <= (hdr_bcnt != '0) ? DATA : CHKSUM;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        xor_acc <= xor_acc ^ rd_fifo_data;
                        if (remaining != '0)
                            remaining <= remaining - BCNT_W'(1);
                        if (remaining == BCNT_W'(1))
                            state <= CHKSUM;
                    end
                end
                CHKSUM: begin
                    if (xfer) begin
                        chksum_err    <= (rd_fifo_data != xor_acc);
                        fill_cntr_dec <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Hold until the request drops so one request yields one fill
                    if (!req_sync)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_readout_sm.sv
// tb/tb_adc_readout_sm.sv - directed self-checking bench for adc_readout_sm
module tb_adc_readout_sm;

    logic         clk = 1'b0;
    logic         reset, readout_req, acq_enable0, acq_enable1, out_ready, stall_empty;
    logic [23:0]  fills_stored;
    logic [127:0] rd_fifo_data, out_data;
    logic         rd_fifo_empty, rd_fifo_rd_en, out_valid, out_last, rd_addr_cntr_en;
    logic         fill_cntr_dec, readout_busy, readout_done, no_data_err, chksum_err;

    logic [127:0] mem [0:63];
    logic [127:0] rx  [0:63];
    int unsigned  wr_ptr = 0;
    int unsigned  rd_ptr = 0;
    int           n_xfer = 0, n_addr = 0, n_dec = 0, n_nodata = 0, n_last = 0, last_at = -1;
    int           b_x, b_a, b_d, b_n, b_l;
    int           tests = 0, fails = 0;

    localparam logic [127:0] H1  = 128'h8000_0000_0000_0000_0000_0000_0080_0003;
    localparam logic [127:0] A1  = 128'h0000_0000_0000_0000_0000_0000_0000_00F0;
    localparam logic [127:0] B1  = 128'h0000_0000_0000_0000_0000_0000_0000_0F00;
    localparam logic [127:0] C1  = 128'h0000_0001_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] K1  = 128'h8000_0001_0000_0000_0000_0000_0080_0FF3;
    localparam logic [127:0] H0  = 128'hABCD_0000_0000_0000_0000_0000_0080_0000;
    localparam logic [127:0] HB  = 128'h3;
    localparam logic [127:0] D1  = 128'h1111;
    localparam logic [127:0] D2  = 128'h2222;
    localparam logic [127:0] D3  = 128'h4444;
    localparam logic [127:0] KB  = 128'h7774;

    always #5 clk = ~clk;

    assign rd_fifo_empty = (rd_ptr == wr_ptr) || stall_empty;
    assign rd_fifo_data  = mem[rd_ptr[5:0]];

    adc_readout_sm dut (
        .clk(clk), .reset(reset), .readout_req(readout_req),
        .acq_enable0(acq_enable0), .acq_enable1(acq_enable1),
        .fills_stored(fills_stored), .rd_fifo_data(rd_fifo_data),
        .rd_fifo_empty(rd_fifo_empty), .rd_fifo_rd_en(rd_fifo_rd_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .rd_addr_cntr_en(rd_addr_cntr_en),
        .fill_cntr_dec(fill_cntr_dec), .readout_busy(readout_busy),
        .readout_done(readout_done), .no_data_err(no_data_err),
        .chksum_err(chksum_err)
    );

    always @(posedge clk) begin
        if (rd_fifo_rd_en) rd_ptr <= rd_ptr + 1;
        if (!reset && out_valid && out_ready) begin
            rx[n_xfer[5:0]] <= out_data;
            n_xfer <= n_xfer + 1;
            if (out_last) begin
                n_last  <= n_last + 1;
                last_at <= n_xfer;
            end
        end
        if (!reset && rd_addr_cntr_en) n_addr <= n_addr + 1;
        if (fill_cntr_dec) n_dec <= n_dec + 1;
        if (no_data_err) n_nodata <= n_nodata + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [127:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic snap();
        b_x = n_xfer; b_a = n_addr; b_d = n_dec; b_n = n_nodata; b_l = n_last;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!readout_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", readout_done, 1'b1);
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int k = 0;
        while (n_xfer < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("xfer_reached", n_xfer, target);
    endtask

    function automatic logic [8:0] outs();
        return {out_valid, rd_fifo_rd_en, rd_addr_cntr_en, out_last, fill_cntr_dec,
                readout_busy, readout_done, no_data_err, chksum_err};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 1'b1; readout_req = 1'b0; acq_enable0 = 1'b0; acq_enable1 = 1'b0;
        out_ready = 1'b1; stall_empty = 1'b0; fills_stored = 24'd5;
        cyc(3);
        check("reset_outs", outs(), 9'h0);
        check("reset_out_data", out_data, 128'h0);
        reset = 1'b0;
        cyc(2);

        // Good fill, burst count 3 (header bit 23 is outside the count field)
        push(H1); push(A1); push(B1); push(C1); push(K1);
        snap();
        readout_req = 1'b1;
        wait_done(40);
        cyc(2);
        check("f1_done_held", readout_done, 1'b1);
        check("f1_xfers", n_xfer - b_x, 5);
        check("f1_addr_pulses", n_addr - b_a, 5);
        check("f1_last_count", n_last - b_l, 1);
        check("f1_last_pos", last_at, b_x + 4);
        check("f1_dec", n_dec - b_d, 1);
        check("f1_chksum_err", chksum_err, 1'b0);
        check("f1_w0", rx[b_x + 0], H1);
        check("f1_w1", rx[b_x + 1], A1);
        check("f1_w2", rx[b_x + 2], B1);
        check("f1_w3", rx[b_x + 3], C1);
        check("f1_w4", rx[b_x + 4], K1);
        readout_req = 1'b0;
        cyc(4);
        check("f1_idle", readout_busy, 1'b0);

        // Corrupted checksum
        push(H1); push(A1); push(B1); push(C1); push(K1 ^ 128'h1);
        snap();
        readout_req = 1'b1;
        wait_done(40);
        cyc(2);
        check("f2_chksum_err", chksum_err, 1'b1);
        check("f2_dec", n_dec - b_d, 1);
        readout_req = 1'b0;
        cyc(4);
        check("f2_err_sticky", chksum_err, 1'b1);

        // Burst count 0, stalled in HDR to observe the error clear
        push(H0); push(H0);
        snap();
        out_ready = 1'b0;
        readout_req = 1'b1;
        cyc(5);
        check("f3_err_cleared", chksum_err, 1'b0);
        check("f3_hdr_valid", out_valid, 1'b1);
        check("f3_hdr_no_pop", rd_fifo_rd_en, 1'b0);
        check("f3_hdr_data", out_data, H0);
        out_ready = 1'b1;
        wait_done(20);
        cyc(2);
        check("f3_xfers", n_xfer - b_x, 2);
        check("f3_last", last_at, b_x + 1);
        check("f3_chksum_err", chksum_err, 1'b0);
        check("f3_dec", n_dec - b_d, 1);
        readout_req = 1'b0;
        cyc(4);

        // No fills stored
        fills_stored = 24'd0;
        snap();
        readout_req = 1'b1;
        wait_done(20);
        cyc(1);
        check("nd_pulse", n_nodata - b_n, 1);
        cyc(5);
        check("nd_single", n_nodata - b_n, 1);
        check("nd_no_pops", n_addr - b_a, 0);
        check("nd_done_held", readout_done, 1'b1);
        check("nd_no_dec", n_dec - b_d, 0);
        readout_req = 1'b0;
        cyc(4);
        check("nd_released", readout_done, 1'b0);
        fills_stored = 24'd5;

        // Backpressure and FIFO underrun mid-DATA
        push(HB); push(D1); push(D2); push(D3); push(KB);
        snap();
        readout_req = 1'b1;
        wait_xfer(b_x + 2, 30);
        out_ready = 1'b0;
        cyc(1);
        check("bp_valid_held", out_valid, 1'b1);
        check("bp_no_pop", rd_fifo_rd_en, 1'b0);
        cyc(1);
        out_ready = 1'b1;
        stall_empty = 1'b1;
        cyc(3);
        check("bp_empty_invalid", out_valid, 1'b0);
        check("bp_no_xfer", n_xfer - b_x, 2);
        stall_empty = 1'b0;
        wait_done(30);
        cyc(2);
        check("bp_xfers", n_xfer - b_x, 5);
        check("bp_w1", rx[b_x + 1], D1);
        check("bp_w2", rx[b_x + 2], D2);
        check("bp_w3", rx[b_x + 3], D3);
        check("bp_w4", rx[b_x + 4], KB);
        check("bp_chksum_err", chksum_err, 1'b0);
        check("bp_dec", n_dec - b_d, 1);
        readout_req = 1'b0;
        cyc(4);

        // Request during acquisition mode is ignored
        acq_enable0 = 1'b1;
        cyc(3);
        snap();
        readout_req = 1'b1;
        cyc(8);
        check("acq_idle", readout_busy, 1'b0);
        readout_req = 1'b0;
        acq_enable0 = 1'b0;
        cyc(4);

        // Reset after header plus two data words
        push(128'h4); push(128'h10); push(128'h20); push(128'h40); push(128'h80); push(128'hF4);
        snap();
        readout_req = 1'b1;
        wait_xfer(b_x + 3, 30);
        check("rst_in_fill", readout_busy, 1'b1);
        out_ready = 1'b0;
        reset = 1'b1;
        cyc(1);
        check("rst_outs", outs(), 9'h0);
        check("rst_out_data", out_data, 128'h0);
        readout_req = 1'b0;
        cyc(3);
        reset = 1'b0;
        out_ready = 1'b1;
        cyc(6);
        check("rst_idle", readout_busy, 1'b0);
        check("rst_no_dec", n_dec - b_d, 0);
        check("rst_xfers", n_xfer - b_x, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
